// File: rtl/gprf_wb_sched.sv
// gprf_wb_sched: shares the single write port of the 8x8 GPR file between
// the ALU and the load unit, and keeps a per-register scoreboard of
// outstanding writes for WAW and read-hazard detection.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   alu_valid/ready/addr/data  ALU write-back handshake
//   mem_valid/ready/addr/data  load-unit write-back handshake
//   wr_en/wr_addr/wr_data      registered register-file write port
//   issue_valid/addr/ready     decode destination reservation
//   rd_a_use/addr, rd_b_use/addr  decode source operands
//   rd_stall                   a used source has a pending write
//   busy                       scoreboard, one bit per register
module gprf_wb_sched (
    input  logic       clk,
    input  logic       reset,
    input  logic       alu_valid,
    output logic       alu_ready,
    input  logic [2:0] alu_addr,
    input  logic [7:0] alu_data,
    input  logic       mem_valid,
    output logic       mem_ready,
    input  logic [2:0] mem_addr,
    input  logic [7:0] mem_data,
    output logic       wr_en,
    output logic [2:0] wr_addr,
    output logic [7:0] wr_data,
    input  logic       issue_valid,
    input  logic [2:0] issue_addr,
    output logic       issue_ready,
    input  logic       rd_a_use,
    input  logic [2:0] rd_a_addr,
    input  logic       rd_b_use,
    input  logic [2:0] rd_b_addr,
    output logic       rd_stall,
    output logic [7:0] busy
);

    localparam int unsigned NREG = 8;
    localparam int unsigned AW   = 3;
    localparam int unsigned DW   = 8;

    // last_grant: 0 = ALU won last transfer, 1 = MEM won last transfer
    logic            last_grant, last_grant_n;
    logic            wr_en_n;
    logic [AW-1:0]   wr_addr_n;
    logic [DW-1:0]   wr_data_n;
    logic [NREG-1:0] busy_n;
    logic [NREG-1:0] set_mask, clr_mask;
    logic            alu_xfer, mem_xfer, issue_fire;

    // Round-robin grant: on a tie the requester that did not win last goes.
    always_comb begin
        alu_ready = alu_valid & (~mem_valid | last_grant);
        mem_ready = mem_valid & (~alu_valid | ~last_grant);
    end

    assign alu_xfer    = alu_valid & alu_ready;
    assign mem_xfer    = mem_valid & mem_ready;
    assign issue_ready = ~busy[issue_addr];
    assign issue_fire  = issue_valid & issue_ready;
    assign rd_stall    = (rd_a_use & busy[rd_a_addr]) | (rd_b_use & busy[rd_b_addr]);

    // Next-state: write port load, arbitration history, scoreboard update.
    always_comb begin
        last_grant_n = last_grant;
        wr_en_n      = 1'b0;
        wr_addr_n    = wr_addr;
        wr_data_n    = wr_data;
        if (alu_xfer) begin
            last_grant_n = 1'b0;
            wr_en_n      = 1'b1;
            wr_addr_n    = alu_addr;
            wr_data_n    = alu_data;
        end else if (mem_xfer) begin
            last_grant_n = 1'b1;
            wr_en_n      = 1'b1;
            wr_addr_n    = mem_addr;
            wr_data_n    = mem_data;
        end
        // Clear lands on the edge the register file captures the data;
        // applying the set after the clear makes set win on a collision.
        clr_mask = wr_en      ? (NREG'(1) << wr_addr)    : '0;
        set_mask = issue_fire ? (NREG'(1) << issue_addr) : '0;
        busy_n   = (busy & ~clr_mask) | set_mask;
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= 1'b1;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            busy       <= '0;
        end else begin
            last_grant <= last_grant_n;
            wr_en      <= wr_en_n;
            wr_addr    <= wr_addr_n;
            wr_data    <= wr_data_n;
            busy       <= busy_n;
        end
    end

endmodule

// File: tb/tb_gprf_wb_sched.sv
// Directed, table-driven bench for gprf_wb_sched. Inputs change on the
// falling edge; combinational outputs are checked before the rising edge and
// registered outputs just after it.
module tb_gprf_wb_sched;

    logic       clk = 1'b0;
    logic       reset;
    logic       alu_valid, alu_ready;
    logic [2:0] alu_addr;
    logic [7:0] alu_data;
    logic       mem_valid, mem_ready;
    logic [2:0] mem_addr;
    logic [7:0] mem_data;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [7:0] wr_data;
    logic       issue_valid, issue_ready;
    logic [2:0] issue_addr;
    logic       rd_a_use, rd_b_use, rd_stall;
    logic [2:0] rd_a_addr, rd_b_addr;
    logic [7:0] busy;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    gprf_wb_sched dut (
        .clk(clk), .reset(reset),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_data(mem_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .issue_valid(issue_valid), .issue_addr(issue_addr), .issue_ready(issue_ready),
        .rd_a_use(rd_a_use), .rd_a_addr(rd_a_addr), .rd_b_use(rd_b_use), .rd_b_addr(rd_b_addr),
        .rd_stall(rd_stall), .busy(busy)
    );

    typedef struct {
        logic       av;  logic [2:0] aa; logic [7:0] ad;
        logic       mv;  logic [2:0] ma; logic [7:0] md;
        logic       iv;  logic [2:0] ia;
        logic       rau; logic [2:0] raa;
        logic       rbu; logic [2:0] rba;
        logic       ear, emr, eir, est;
        logic       ewe; logic [2:0] ewa; logic [7:0] ewd; logic [7:0] ebz;
    } vec_t;

    function automatic vec_t mkv(
        input logic av, input logic [2:0] aa, input logic [7:0] ad,
        input logic mv, input logic [2:0] ma, input logic [7:0] md,
        input logic iv, input logic [2:0] ia,
        input logic rau, input logic [2:0] raa, input logic rbu, input logic [2:0] rba,
        input logic ear, input logic emr, input logic eir, input logic est,
        input logic ewe, input logic [2:0] ewa, input logic [7:0] ewd, input logic [7:0] ebz);
        vec_t v;
        v.av = av;   v.aa = aa;   v.ad = ad;
        v.mv = mv;   v.ma = ma;   v.md = md;
        v.iv = iv;   v.ia = ia;
        v.rau = rau; v.raa = raa; v.rbu = rbu; v.rba = rba;
        v.ear = ear; v.emr = emr; v.eir = eir; v.est = est;
        v.ewe = ewe; v.ewa = ewa; v.ewd = ewd; v.ebz = ebz;
        return v;
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        alu_valid = 0; alu_addr = 0; alu_data = 0;
        mem_valid = 0; mem_addr = 0; mem_data = 0;
        issue_valid = 0; issue_addr = 0;
        rd_a_use = 0; rd_a_addr = 0; rd_b_use = 0; rd_b_addr = 0;
    endtask

    // One full cycle: drive, check handshakes/hazard, clock, check registers.
    task automatic apply(input string tag, input vec_t v);
        @(negedge clk);
        alu_valid = v.av; alu_addr = v.aa; alu_data = v.ad;
        mem_valid = v.mv; mem_addr = v.ma; mem_data = v.md;
        issue_valid = v.iv; issue_addr = v.ia;
        rd_a_use = v.rau; rd_a_addr = v.raa; rd_b_use = v.rbu; rd_b_addr = v.rba;
        #1;
        check({tag, ".alu_ready"},   8'(alu_ready),   8'(v.ear));
        check({tag, ".mem_ready"},   8'(mem_ready),   8'(v.emr));
        check({tag, ".issue_ready"}, 8'(issue_ready), 8'(v.eir));
        check({tag, ".rd_stall"},    8'(rd_stall),    8'(v.est));
        @(posedge clk); #1;
        check({tag, ".wr_en"},   8'(wr_en),   8'(v.ewe));
        check({tag, ".wr_addr"}, 8'(wr_addr), 8'(v.ewa));
        check({tag, ".wr_data"}, wr_data,     v.ewd);
        check({tag, ".busy"},    busy,        v.ebz);
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clk);
        reset = 1;
        for (int i = 0; i < cycles; i++) begin
            alu_valid = 1'($urandom); alu_addr = 3'($urandom); alu_data = 8'($urandom);
            mem_valid = 1'($urandom); mem_addr = 3'($urandom); mem_data = 8'($urandom);
            issue_valid = 1'($urandom); issue_addr = 3'($urandom);
            rd_a_use = 1'($urandom); rd_a_addr = 3'($urandom);
            rd_b_use = 1'($urandom); rd_b_addr = 3'($urandom);
            @(posedge clk); #1;
            if (i < cycles - 1) @(negedge clk);
        end
        check("rst.wr_en",   8'(wr_en),   8'h00);
        check("rst.wr_addr", 8'(wr_addr), 8'h00);
        check("rst.wr_data", wr_data,     8'h00);
        check("rst.busy",    busy,        8'h00);
        @(negedge clk);
        reset = 0;
        idle_inputs();
    endtask

    vec_t tbl [12];

    initial begin
        reset = 1;
        idle_inputs();

        //           ALU            MEM            issue  rdA    rdB    ar mr ir st  we wa wd     busy
        tbl[0]  = mkv(1,1,8'h11, 1,2,8'h22, 0,0, 0,0, 0,0, 1,0,1,0, 1,1,8'h11,8'h00); // first tie -> ALU
        tbl[1]  = mkv(1,1,8'h11, 1,2,8'h22, 0,0, 0,0, 0,0, 0,1,1,0, 1,2,8'h22,8'h00);
        tbl[2]  = mkv(1,1,8'h11, 1,2,8'h22, 0,0, 0,0, 0,0, 1,0,1,0, 1,1,8'h11,8'h00);
        tbl[3]  = mkv(1,1,8'h11, 1,2,8'h22, 0,0, 0,0, 0,0, 0,1,1,0, 1,2,8'h22,8'h00);
        tbl[4]  = mkv(0,0,8'h00, 0,0,8'h00, 1,3, 0,0, 0,0, 0,0,1,0, 0,2,8'h22,8'h08); // issue r3, hold port
        tbl[5]  = mkv(0,0,8'h00, 1,3,8'h5A, 0,3, 1,3, 0,0, 0,1,0,1, 1,3,8'h5A,8'h08); // MEM writes r3
        tbl[6]  = mkv(0,0,8'h00, 0,0,8'h00, 0,3, 1,3, 0,0, 0,0,0,1, 0,3,8'h5A,8'h00); // clear at this edge
        tbl[7]  = mkv(0,0,8'h00, 0,0,8'h00, 0,3, 1,3, 1,3, 0,0,1,0, 0,3,8'h5A,8'h00);
        tbl[8]  = mkv(1,4,8'h44, 1,5,8'h55, 1,4, 0,0, 0,0, 1,0,1,0, 1,4,8'h44,8'h10); // tie after MEM -> ALU
        tbl[9]  = mkv(0,0,8'h00, 1,5,8'h55, 1,4, 0,0, 1,4, 0,1,0,1, 1,5,8'h55,8'h00); // WAW blocked on r4
        tbl[10] = mkv(0,0,8'h00, 0,0,8'h00, 1,4, 0,0, 0,0, 0,0,1,0, 0,5,8'h55,8'h10); // r4 reissued
        tbl[11] = mkv(0,0,8'h00, 0,0,8'h00, 1,5, 1,4, 0,0, 0,0,1,1, 0,5,8'h55,8'h30); // r5 accepted, r4 busy

        do_reset(2);
        for (int i = 0; i < 12; i++) apply($sformatf("v%0d", i), tbl[i]);

        // Simultaneous set/clear on the same register, then on different ones.
        do_reset(2);
        apply("sc0", mkv(0,0,8'h00, 1,6,8'h66, 0,0, 0,0, 0,0, 0,1,1,0, 1,6,8'h66,8'h00));
        apply("sc1", mkv(0,0,8'h00, 0,0,8'h00, 1,6, 0,0, 0,0, 0,0,1,0, 0,6,8'h66,8'h40));
        apply("sc2", mkv(0,0,8'h00, 1,6,8'h67, 0,6, 1,6, 0,0, 0,1,0,1, 1,6,8'h67,8'h40));
        apply("sc3", mkv(0,0,8'h00, 0,0,8'h00, 1,7, 0,0, 0,0, 0,0,1,0, 0,6,8'h67,8'h80));

        // Reset right after an accepted transfer drops the pending write.
        apply("rm0", mkv(1,1,8'h99, 0,0,8'h00, 1,1, 0,0, 0,0, 1,0,1,0, 1,1,8'h99,8'h82));
        @(negedge clk);
        reset = 1;
        idle_inputs();
        @(posedge clk); #1;
        check("rm1.wr_en",   8'(wr_en),   8'h00);
        check("rm1.wr_addr", 8'(wr_addr), 8'h00);
        check("rm1.wr_data", wr_data,     8'h00);
        check("rm1.busy",    busy,        8'h00);
        @(negedge clk);
        reset = 0;
        apply("rm2", mkv(0,0,8'h00, 0,0,8'h00, 0,0, 1,1, 1,7, 0,0,1,0, 0,0,8'h00,8'h00));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
